bcd_to_binary_seq: RTL and testbench

Sequential reverse double-dabble converter. It takes a 5-digit BCD magnitude plus a sign flag and produces a 16-bit two's-complement value. It is the entry-side counterpart of the display path: digits collected from the pushbutton/keypad front end are converted back into the binary operand bus. It runs on the divided display clock and uses a start/done handshake.

---
 rtl/bcd_to_binary_seq_pkg.sv | 30 +++
 rtl/bcd_to_binary_seq_nibble_adjust.sv | 22 ++
 rtl/bcd_to_binary_seq.sv | 183 ++++++++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_to_binary_seq_pkg.sv
// ============================================================================
// bcd_to_binary_seq_pkg : shared constants and state encoding for the
//                         sequential BCD-to-binary converter.
// Rev 1.0
// ============================================================================
`default_nettype none

package bcd_to_binary_seq_pkg;

    localparam int C_DIGITS = 5;
    localparam int C_WIDTH  = 16;
    localparam int C_BCD_W  = 4 * C_DIGITS;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_SHIFT  = 2'd1;
    localparam state_t S_FINISH = 2'd2;

    localparam int unsigned C_MAX_POS     = 32767;
    localparam int unsigned C_MAX_NEG_MAG = 32768;
    localparam logic [15:0] C_SAT_POS     = 16'h7FFF;
    localparam logic [15:0] C_SAT_NEG     = 16'h8000;

    function automatic logic nibble_invalid(input logic [3:0] i_nib);
        return (i_nib > 4'd9);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_to_binary_seq_nibble_adjust.sv
// ============================================================================
// bcd_nibble_adjust : reverse double-dabble correction, subtracts 3 from a
//                     nibble that is 8 or more.
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_nibble_adjust (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    always_comb begin
        o_nib = i_nib;
        if (i_nib >= 4'd8) begin
            o_nib = i_nib - 4'd3;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_to_binary_seq.sv
// ============================================================================
// bcd_to_binary_seq : sequential reverse double-dabble, signed BCD magnitude
//                     to saturated two's-complement, start/done handshake.
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_to_binary_seq
    import bcd_to_binary_seq_pkg::*;
#(
    parameter int DIGITS = C_DIGITS,
    parameter int WIDTH  = C_WIDTH
) (
    input  logic                  clkout,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic                  sign,
    output logic [WIDTH-1:0]      binary,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int ITER_W = $clog2(BCD_W + 1);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   r_mag;
    logic [ITER_W-1:0]  r_iter;
    logic               r_sign;
    logic               r_inv;
    logic [WIDTH-1:0]   r_bin;
    logic               r_done;
    logic               r_err;

    logic               w_inv;
    logic               w_busy;
    logic               w_load;
    logic               w_shift;
    logic               w_finish;
    logic               w_last_shift;
    logic [BCD_W-1:0]   w_bcd_shift;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [WIDTH-1:0]   w_mag_lo;
    logic [WIDTH-1:0]   w_res_bin;
    logic               w_res_err;

    always_comb begin
        w_inv = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (nibble_invalid(bcd[4*d +: 4])) begin
                w_inv = 1'b1;
            end
        end
    end

    // Shift first, then correct every nibble of the shifted BCD word.
    assign w_bcd_shift = {1'b0, r_bcd[BCD_W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_nibble_adjust u_adj (
            .i_nib (w_bcd_shift[4*g +: 4]),
            .o_nib (w_bcd_adj[4*g +: 4])
        );
    end

    assign w_last_shift = (r_iter == ITER_W'(BCD_W - 1));

    always_ff @(posedge clkout or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The done cycle is spent in IDLE with start masked, so held starts
    // are spaced one cycle beyond the done pulse.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && !r_done) begin
                    w_state_nxt = w_inv ? S_FINISH : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last_shift) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = (r_state != S_IDLE);
        w_load   = (r_state == S_IDLE) && start && !r_done;
        w_shift  = (r_state == S_SHIFT);
        w_finish = (r_state == S_FINISH);
    end

    // Range checks compare the full magnitude so 99999 never aliases.
    assign w_mag_lo = WIDTH'(r_mag);

    always_comb begin
        w_res_bin = '0;
        w_res_err = 1'b0;
        if (r_inv) begin
            w_res_err = 1'b1;
        end else if (!r_sign) begin
            if (r_mag > BCD_W'(C_MAX_POS)) begin
                w_res_bin = WIDTH'(C_SAT_POS);
                w_res_err = 1'b1;
            end else begin
                w_res_bin = w_mag_lo;
            end
        end else begin
            if (r_mag > BCD_W'(C_MAX_NEG_MAG)) begin
                w_res_bin = WIDTH'(C_SAT_NEG);
                w_res_err = 1'b1;
            end else begin
                w_res_bin = '0 - w_mag_lo;
            end
        end
    end

    always_ff @(posedge clkout or posedge rst) begin
        if (rst) begin
            r_bcd  <= '0;
            r_mag  <= '0;
            r_iter <= '0;
            r_sign <= 1'b0;
            r_inv  <= 1'b0;
            r_bin  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else if (clr) begin
            r_bcd  <= '0;
            r_mag  <= '0;
            r_iter <= '0;
            r_sign <= 1'b0;
            r_inv  <= 1'b0;
            r_bin  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_bcd  <= bcd;
                r_sign <= sign;
                r_inv  <= w_inv;
                r_mag  <= '0;
                r_iter <= '0;
            end
            if (w_shift) begin
                r_bcd  <= w_bcd_adj;
                r_mag  <= {r_bcd[0], r_mag[BCD_W-1:1]};
                r_iter <= r_iter + 1'b1;
            end
            if (w_finish) begin
                r_bin <= w_res_bin;
                r_err <= w_res_err;
            end
        end
    end

    assign binary = r_bin;
    assign busy   = w_busy;
    assign done   = r_done;
    assign err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_binary_seq.sv
// ============================================================================
// tb_bcd_to_binary_seq : directed vectors with a queue scoreboard; a monitor
//                        pops expectations on every done pulse.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bcd_to_binary_seq;

    logic        clkout = 1'b0;
    logic        rst;
    logic        clr;
    logic        start;
    logic [19:0] bcd;
    logic        sign;
    logic [15:0] binary;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct packed {
        logic [15:0] bin;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    bcd_to_binary_seq dut (
        .clkout (clkout),
        .rst    (rst),
        .clr    (clr),
        .start  (start),
        .bcd    (bcd),
        .sign   (sign),
        .binary (binary),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clkout = ~clkout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clkout) begin : mon
        exp_t e;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("binary", 32'(binary), 32'(e.bin));
                check("err", 32'(err), 32'(e.err));
            end
        end
    end

    // lat: clock edges from the start edge to the edge that raises done.
    task automatic convert(input logic [19:0] v, input logic s,
                           input logic [15:0] eb, input logic ee, input int lat);
        int n_edge;
        int n_busy;
        bit seen;
        @(negedge clkout);
        bcd   = v;
        sign  = s;
        start = 1'b1;
        exp_q.push_back('{bin: eb, err: ee});
        @(posedge clkout);
        #1;
        start  = 1'b0;
        bcd    = 20'hFFFFF;
        sign   = ~s;
        n_busy = busy ? 1 : 0;
        n_edge = 0;
        seen   = 1'b0;
        while (!seen && n_edge < 40) begin
            @(posedge clkout);
            #1;
            n_edge++;
            if (done) seen = 1'b1;
            else if (busy) n_busy++;
        end
        check("done_timeout", 32'(seen), 32'(1));
        check("done_latency", 32'(n_edge), 32'(lat));
        check("busy_cycles", 32'(n_busy), 32'(lat));
        @(posedge clkout);
    endtask

    task automatic count_dones(input int cycles, output int nd);
        nd = 0;
        repeat (cycles) begin
            @(posedge clkout);
            #1;
            if (done) nd++;
        end
    endtask

    function automatic logic [19:0] b2b_bcd(input int k);
        case (k)
            0:       return 20'h00123;
            23:      return 20'h01000;
            46:      return 20'h65535;
            default: return 20'h98765;
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        int done_k[$];

        rst   = 1'b1;
        clr   = 1'b0;
        start = 1'b0;
        bcd   = '0;
        sign  = 1'b0;
        repeat (3) @(posedge clkout);
        #1;
        check("reset_binary", 32'(binary), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_err", 32'(err), 32'(0));
        @(negedge clkout);
        rst = 1'b0;
        @(posedge clkout);

        convert(20'h12345, 1'b0, 16'h3039, 1'b0, 21);
        repeat (5) @(posedge clkout);
        #1;
        check("binary_hold", 32'(binary), 32'(16'h3039));
        convert(20'h32768, 1'b1, 16'h8000, 1'b0, 21);
        convert(20'h32768, 1'b0, 16'h7FFF, 1'b1, 21);
        convert(20'h32767, 1'b0, 16'h7FFF, 1'b0, 21);
        convert(20'h0A000, 1'b0, 16'h0000, 1'b1, 1);
        convert(20'h0000F, 1'b1, 16'h0000, 1'b1, 1);
        convert(20'h00000, 1'b1, 16'h0000, 1'b0, 21);
        convert(20'h99999, 1'b1, 16'h8000, 1'b1, 21);
        convert(20'h00001, 1'b1, 16'hFFFF, 1'b0, 21);
        convert(20'h12345, 1'b0, 16'h3039, 1'b0, 21);

        // Asynchronous reset during the tenth shift.
        @(negedge clkout);
        bcd   = 20'h54321;
        sign  = 1'b0;
        start = 1'b1;
        @(posedge clkout);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clkout);
        #2;
        rst = 1'b1;
        #1;
        check("rst_abort_binary", 32'(binary), 32'(0));
        check("rst_abort_busy", 32'(busy), 32'(0));
        @(negedge clkout);
        rst = 1'b0;
        count_dones(30, nd);
        check("rst_abort_no_done", 32'(nd), 32'(0));
        convert(20'h00007, 1'b0, 16'h0007, 1'b0, 21);

        // Synchronous clear during the tenth shift.
        @(negedge clkout);
        bcd   = 20'h54321;
        sign  = 1'b0;
        start = 1'b1;
        @(posedge clkout);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clkout);
        @(negedge clkout);
        clr = 1'b1;
        @(posedge clkout);
        #1;
        check("clr_abort_binary", 32'(binary), 32'(0));
        check("clr_abort_busy", 32'(busy), 32'(0));
        @(negedge clkout);
        clr = 1'b0;
        count_dones(30, nd);
        check("clr_abort_no_done", 32'(nd), 32'(0));
        convert(20'h00007, 1'b0, 16'h0007, 1'b0, 21);

        // start held high with bcd changing every cycle.
        exp_q.push_back('{bin: 16'h007B, err: 1'b0});
        exp_q.push_back('{bin: 16'hFC18, err: 1'b0});
        exp_q.push_back('{bin: 16'h7FFF, err: 1'b1});
        for (int k = 0; k < 70; k++) begin
            @(negedge clkout);
            start = (k <= 68);
            bcd   = b2b_bcd(k);
            sign  = (k == 23);
            @(posedge clkout);
            #1;
            if (done) done_k.push_back(k);
        end
        start = 1'b0;
        check("b2b_done_count", 32'(done_k.size()), 32'(3));
        for (int i = 0; i < 3; i++) begin
            if (i < done_k.size()) begin
                check("b2b_done_edge", 32'(done_k[i]), 32'(21 + 23 * i));
            end
        end

        repeat (5) @(posedge clkout);
        check("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
